// File: rtl/hex_line_formatter_if.sv
// hex_line_formatter_if
//   Groups the word-input and byte-output handshakes of hex_line_formatter.
//   slave  : the formatter side (takes words, produces bytes)
//   master : the producer/sink side (supplies words, accepts bytes)
// Signals:
//   in_data    [WIDTH-1:0]  word to print, MSB nibble first
//   in_valid                in_data is valid
//   in_ready                formatter can accept a word this cycle
//   out_ready               byte sink can take a byte
//   out_data   [7:0]        ASCII byte
//   out_strobe              one-cycle pulse, out_data valid
interface hex_line_formatter_if #(
  parameter int WIDTH = 28
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_strobe;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_strobe
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_strobe
  );
endinterface

// File: rtl/hex_line_formatter.sv
// hex_line_formatter
//   Prints one WIDTH-bit word per line as uppercase hex ASCII, MSB nibble
//   first, optionally split by a single space before the last SPLIT digits,
//   terminated by LF then CR. One byte per clock at most.
//
//   Optional checksum: define HEX_LINE_CHECKSUM_EN to append " X" (space plus
//   the XOR of all nibbles as one hex digit) before the line terminator.
//
// Parameters:
//   WIDTH  input word width, multiple of 4, 4..64
//   SPLIT  digits placed after the space (0 = no space), < WIDTH/4
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    hex_line_formatter_if slave modport (word in, byte out)
//
// Timing: out_ready is sampled at the rising edge that would register a
// byte; the byte appears on out_data/out_strobe in the cycle after that
// edge. The first digit is registered by the same edge that accepts the
// word, so a line starts in the cycle right after acceptance.
//
// state  | meaning
// IDLE   | waiting for a word (in_ready high once the last CR has gone out)
// DIGIT  | emitting hex digits of the latched word
// SPACE  | emitting the split space
// CHK_SP | emitting the space before the checksum digit (checksum build)
// CHK    | emitting the checksum digit (checksum build)
// LF     | emitting 0x0A
// CR     | emitting 0x0D, then back to IDLE
module hex_line_formatter #(
  parameter int WIDTH = 28,
  parameter int SPLIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  hex_line_formatter_if.slave bus
);
  localparam int NDIG = WIDTH / 4;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] NDIG_C  = CW'(NDIG);
  localparam logic [CW-1:0] SPLIT_C = CW'(SPLIT);

  typedef enum logic [2:0] {
    IDLE,
    DIGIT,
    SPACE,
`ifdef HEX_LINE_CHECKSUM_EN
    CHK_SP,
    CHK,
`endif
    LF,
    CR
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] word, word_n, src_word;
  logic [CW-1:0]    rem, rem_n, src_rem;
  logic             strobe_q, strobe_n;
  logic [7:0]       data_q, data_n;
  logic             digit_go;
  logic [3:0]       nib;
  logic             accept;
`ifdef HEX_LINE_CHECKSUM_EN
  logic [3:0]       chk, chk_n, src_chk;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The CR strobe cycle is already IDLE; holding in_ready off for it leaves
  // exactly one idle cycle between back-to-back lines.
  assign bus.in_ready   = (state == IDLE) && !strobe_q && !reset;
  assign bus.out_strobe = strobe_q;
  assign bus.out_data   = data_q;
  assign accept         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_n  = state;
    word_n   = word;
    rem_n    = rem;
    strobe_n = 1'b0;
    data_n   = data_q;
    src_word = word;
    src_rem  = rem;
    digit_go = 1'b0;
`ifdef HEX_LINE_CHECKSUM_EN
    chk_n    = chk;
    src_chk  = chk;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          // Digit step below works on the incoming word directly so the
          // first digit can leave on the accepting edge.
          src_word = bus.in_data;
          src_rem  = NDIG_C;
          word_n   = bus.in_data;
          rem_n    = NDIG_C;
`ifdef HEX_LINE_CHECKSUM_EN
          src_chk  = 4'h0;
          chk_n    = 4'h0;
`endif
          state_n  = DIGIT;
          digit_go = bus.out_ready;
        end
      end
      DIGIT: digit_go = bus.out_ready;
      SPACE: begin
        if (bus.out_ready) begin
          strobe_n = 1'b1;
          data_n   = 8'h20;
          state_n  = DIGIT;
        end
      end
`ifdef HEX_LINE_CHECKSUM_EN
      CHK_SP: begin
        if (bus.out_ready) begin
          strobe_n = 1'b1;
          data_n   = 8'h20;
          state_n  = CHK;
        end
      end
      CHK: begin
        if (bus.out_ready) begin
          strobe_n = 1'b1;
          data_n   = hex_ascii(chk);
          state_n  = LF;
        end
      end
`endif
      LF: begin
        if (bus.out_ready) begin
          strobe_n = 1'b1;
          data_n   = 8'h0A;
          state_n  = CR;
        end
      end
      CR: begin
        if (bus.out_ready) begin
          strobe_n = 1'b1;
          data_n   = 8'h0D;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    nib = src_word[WIDTH-1 -: 4];
    if (digit_go) begin
      strobe_n = 1'b1;
      data_n   = hex_ascii(nib);
      word_n   = src_word << 4;
      rem_n    = src_rem - CW'(1);
`ifdef HEX_LINE_CHECKSUM_EN
      chk_n    = src_chk ^ nib;
`endif
      if (rem_n == '0) begin
`ifdef HEX_LINE_CHECKSUM_EN
        state_n = CHK_SP;
`else
        state_n = LF;
`endif
      end else if ((SPLIT != 0) && (rem_n == SPLIT_C)) begin
        state_n = SPACE;
      end else begin
        state_n = DIGIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word     <= '0;
      rem      <= '0;
      strobe_q <= 1'b0;
      data_q   <= 8'h00;
`ifdef HEX_LINE_CHECKSUM_EN
      chk      <= 4'h0;
`endif
    end else begin
      state    <= state_n;
      word     <= word_n;
      rem      <= rem_n;
      strobe_q <= strobe_n;
      data_q   <= data_n;
`ifdef HEX_LINE_CHECKSUM_EN
      chk      <= chk_n;
`endif
    end
  end
endmodule

// File: tb/tb_hex_line_formatter.sv
// tb_hex_line_formatter
//   Directed bench for hex_line_formatter: a WIDTH=28/SPLIT=4 instance and a
//   WIDTH=8/SPLIT=0 instance share clock and reset. Expected lines are
//   written out by hand; the checksum digit is appended when the build
//   defines HEX_LINE_CHECKSUM_EN.
module tb_hex_line_formatter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hex_line_formatter_if #(.WIDTH(28)) bus_a ();
  hex_line_formatter_if #(.WIDTH(8))  bus_b ();

  hex_line_formatter #(.WIDTH(28), .SPLIT(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  hex_line_formatter #(.WIDTH(8),  .SPLIT(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

`ifdef HEX_LINE_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // rdy_log[k] = out_ready as seen by rising edge k
  bit rdy_log [0:8191];
  byte unsigned qa_d[$];
  int           qa_c[$];
  byte unsigned qb_d[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc < 8190) rdy_log[cyc + 1] <= bus_a.out_ready;
  end

  always @(negedge clk) begin
    if (bus_a.out_strobe) begin
      qa_d.push_back(bus_a.out_data);
      qa_c.push_back(cyc);
    end
    if (bus_b.out_strobe) qb_d.push_back(bus_b.out_data);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string line(input string body, input string ck);
    return CK ? {body, " ", ck} : body;
  endfunction

  // Offer a word to instance A; acc returns the index of the accepting edge.
  task automatic send_a(input logic [27:0] w, output int acc);
    int k;
    acc = -1;
    bus_a.in_data  = w;
    bus_a.in_valid = 1'b1;
    k = 0;
    while (acc < 0 && k < 50) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end
      k++;
    end
    bus_a.in_valid = 1'b0;
    check("accept", acc >= 0, 1'b1);
  endtask

  // Pop one line (txt + LF + CR) from a strobe queue and compare it.
  task automatic check_line(input bit sel_b, input string tag, input string txt,
                            input int start, input bit gate);
    int n;
    int c;
    byte unsigned e;
    byte unsigned d;
    n = txt.len() + 2;
    check({tag, " count"}, (sel_b ? qb_d.size() : qa_d.size()) >= n, 1'b1);
    for (int i = 0; i < n; i++) begin
      if ((sel_b ? qb_d.size() : qa_d.size()) == 0) break;
      if (i < txt.len())       e = txt[i];
      else if (i == txt.len()) e = 8'h0A;
      else                     e = 8'h0D;
      if (sel_b) begin
        d = qb_d.pop_front();
        c = -1;
      end else begin
        d = qa_d.pop_front();
        c = qa_c.pop_front();
      end
      check($sformatf("%s byte%0d", tag, i), d, e);
      if (!sel_b && start >= 0) check($sformatf("%s cyc%0d", tag, i), c, start + i);
      if (!sel_b && gate && c >= 0 && c < 8192)
        check($sformatf("%s ready%0d", tag, i), rdy_log[c], 1'b1);
    end
  endtask

  initial begin
    int    acc;
    int    acc1;
    int    acc2;
    int    k;
    int    rdy_seen;
    int    n0;
    string s;

    reset           = 1'b1;
    bus_a.in_data   = '0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_data   = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;

    // reset state
    repeat (2) step();
    @(negedge clk);
    check("rst in_ready", bus_a.in_ready, 1'b0);
    check("rst strobe", bus_a.out_strobe, 1'b0);
    check("rst data", bus_a.out_data, 8'h00);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", bus_a.in_ready, 1'b1);
    step();

    // basic line, out_ready held high
    send_a(28'hA012345, acc);
    repeat (16) step();
    check_line(1'b0, "basic", line("A01 2345", "B"), acc, 1'b0);
    check("basic extra", qa_d.size(), 0);

    send_a(28'h89ABCDE, acc);
    repeat (16) step();
    check_line(1'b0, "hexaf", line("89A BCDE", "F"), acc, 1'b0);
    check("hexaf extra", qa_d.size(), 0);

    // out_ready toggling 1,0,0,1,0,0,... from the acceptance cycle
    send_a(28'hA012345, acc);
    for (int j = 1; j < 45; j++) begin
      bus_a.out_ready = (j % 3 == 0);
      step();
    end
    bus_a.out_ready = 1'b1;
    repeat (4) step();
    check_line(1'b0, "toggle", line("A01 2345", "B"), -1, 1'b1);
    check("toggle extra", qa_d.size(), 0);

    // back-to-back words with in_valid held high
    s  = line("000 0000", "0");
    n0 = s.len() + 2;
    bus_a.in_data  = 28'h0000000;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    check("b2b ready first", bus_a.in_ready, 1'b1);
    @(posedge clk);
    #1;
    acc1 = cyc;
    bus_a.in_data = 28'hFFFFFFF;
    rdy_seen = 0;
    for (int i = 0; i < n0; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) rdy_seen++;
    end
    check("b2b ready during line", rdy_seen, 0);
    @(negedge clk);
    check("b2b ready after CR", bus_a.in_ready, 1'b1);
    @(posedge clk);
    #1;
    acc2 = cyc;
    bus_a.in_valid = 1'b0;
    check("b2b second accept edge", acc2, acc1 + n0 + 1);
    repeat (16) step();
    check_line(1'b0, "b2b l1", s, acc1, 1'b0);
    check_line(1'b0, "b2b l2", line("FFF FFFF", "F"), acc2, 1'b0);
    check("b2b extra", qa_d.size(), 0);

    // reset mid-line, applied at the edge after the 3rd digit strobe
    send_a(28'h7654321, acc);
    k = 0;
    while (qa_d.size() < 3 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("midrst reached 3", qa_d.size() >= 3, 1'b1);
    reset = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("midrst strobe", bus_a.out_strobe, 1'b0);
    check("midrst in_ready", bus_a.in_ready, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst ready after", bus_a.in_ready, 1'b1);
    repeat (4) step();
    check("midrst bytes", qa_d.size(), 3);
    s = "765";
    for (int i = 0; i < 3; i++) begin
      if (qa_d.size() == 0) break;
      check($sformatf("midrst byte%0d", i), qa_d.pop_front(), s[i]);
      void'(qa_c.pop_front());
    end
    qa_d.delete();
    qa_c.delete();
    send_a(28'h1234567, acc);
    repeat (16) step();
    check_line(1'b0, "after rst", line("123 4567", "0"), acc, 1'b0);
    check("after rst extra", qa_d.size(), 0);

    // narrow instance, no split
    bus_b.in_data  = 8'h5C;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    check("narrow ready", bus_b.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    repeat (10) step();
    check_line(1'b1, "narrow", line("5C", "9"), -1, 1'b0);
    check("narrow extra", qb_d.size(), 0);
    check("narrow leaves A quiet", qa_d.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hex_line_formatter.md
HEX_LINE_FORMATTER -- requirements
Module: hex_line_formatter

Interface
REQ-001 SHALL have parameter WIDTH, default 28, meaning input word width in bits; multiple of 4, range 4..64.
REQ-002 SHALL have parameter SPLIT, default 4, meaning the number of trailing digits placed after a single space; 0 means no space; must be less than WIDTH/4.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  WIDTH  word to print, MSB nibble first.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port out_ready  input  1  downstream byte sink (UART TX FIFO) can take a byte.
REQ-009 SHALL have port out_data  output  8  ASCII byte.
REQ-010 SHALL have port out_strobe  output  1  one-cycle pulse; out_data valid this cycle.

Function
REQ-011 SHALL use states IDLE, DIGIT, SPACE, CHK_SP, CHK, LF and CR.
REQ-012 SHALL assert in_ready only in IDLE; a word is accepted on a cycle with in_valid && in_ready.
REQ-013 SHALL latch in_data on acceptance and move to DIGIT; the first out_strobe occurs no earlier than the next cycle.
REQ-014 SHALL emit at most one byte per cycle, only on cycles with out_ready high; with out_ready low, state, out_data and the remaining digit count hold and out_strobe is 0.
REQ-015 SHALL render each nibble as uppercase ASCII: 0-9 as 0x30-0x39, A-F as 0x41-0x46.
REQ-016 SHALL emit WIDTH/4 digits MSB first, shifting the latched word left by 4 after each digit.
REQ-017 SHALL, when SPLIT is nonzero, emit one 0x20 byte (SPACE) when exactly SPLIT digits remain, then resume DIGIT.
REQ-018 SHALL terminate each line with 0x0A (LF) then 0x0D (CR), then return to IDLE.
REQ-019 SHALL, with out_ready held high, produce a line of WIDTH/4 + (SPLIT?1:0) + 2 bytes on consecutive cycles, plus 2 bytes when the checksum option is enabled.
REQ-020 SHALL be ready again (in_ready=1) on the cycle after the CR strobe; back-to-back words produce back-to-back lines with one idle cycle between them.
REQ-021 SHALL ignore in_valid while not in IDLE; the upstream holds the word, and nothing is dropped or duplicated.
REQ-022 SHALL drive out_strobe only as a registered output; out_data is stable while out_strobe is high.

Reset
REQ-023 SHALL, on reset, force state IDLE, out_strobe=0, out_data=0x00, in_ready=0 during reset and 1 on the first cycle after it, latched word=0, and checksum accumulator=0.
REQ-024 SHALL, on reset mid-line, abandon the line immediately with no further bytes; the partial line is not completed.

Configuration
REQ-025 SHALL compile a checksum digit in when macro HEX_LINE_CHECKSUM_EN is defined: a 4-bit XOR of all WIDTH/4 nibbles, cleared on acceptance, emitted after the last data digit as 0x20 (CHK_SP) and then one hex digit (CHK), before LF.
REQ-026 SHALL, without HEX_LINE_CHECKSUM_EN, omit the CHK_SP and CHK states and the accumulator entirely, so that DIGIT goes directly to LF.

Verification
REQ-027 SHALL cover this case: WIDTH=28, SPLIT=4, macro off, out_ready=1, in_data=0xA012345 -> bytes "A01 2345" 0x0A 0x0D on 10 consecutive cycles starting the cycle after acceptance.
REQ-028 SHALL cover this case: the same word with HEX_LINE_CHECKSUM_EN defined -> "A01 2345 B" 0x0A 0x0D, 12 bytes.
REQ-029 SHALL cover this case: out_ready toggling 1,0,0,1,... during the line -> the same 10 bytes, with no strobe on any out_ready=0 cycle and no byte lost or repeated.
REQ-030 SHALL cover this case: in_valid held high with words 0x0000000 then 0xFFFFFFF -> lines "000 0000" and "FFF FFFF", second accepted exactly one cycle after the first CR, with in_ready=0 throughout the first line.
REQ-031 SHALL cover this case: reset asserted on the cycle after the 3rd digit strobe -> no further strobes, in_ready=1 after reset release, and the next word 0x1234567 prints "123 4567" cleanly.
REQ-032 SHALL cover this case: WIDTH=8, SPLIT=0, in_data=0x5C -> "5C" 0x0A 0x0D, 4 bytes, with no space.
